xadc_scan_avg: RTL and testbench

Parametrised successor to the single-channel XADC read path. It drives the XADC DRP port itself and round-robins over NUM_CH auxiliary channel addresses, skipping channels masked off by a runtime enable. For each channel it averages 2^AVG_LOG2 consecutive conversions and flags over-range samples. A free-running frame timer snapshots all channel averages for the display/BCD stage, so no 100 ms polling logic is needed downstream.

---
 rtl/xadc_scan_avg.sv | 205 ++++++++++++++++++++
 tb/tb_xadc_scan_avg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_scan_avg.sv
// Round-robin XADC DRP scanner: burst-averages each enabled channel, flags over-range
// samples and snapshots the latest per-channel averages on a free-running frame timer.
module xadc_scan_avg #(
    parameter int unsigned         NUM_CH       = 4,
    parameter logic [7*NUM_CH-1:0] ADDR_LIST    = {7'h1F, 7'h1E, 7'h17, 7'h16},
    parameter int unsigned         AVG_LOG2     = 2,
    parameter int unsigned         FRAME_CYCLES = 10_000_000,
    parameter logic [15:0]         OVR_THRESH   = 16'hFFD0,
    parameter int unsigned         DRDY_TIMEOUT = 255
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic                  eoc_in,
    input  logic                  drdy_in,
    input  logic [15:0]           do_in,
    output logic                  den_out,
    output logic [6:0]            daddr_out,
    output logic [15:0]           sample_data,
    output logic [2:0]            sample_ch,
    output logic                  sample_valid,
    output logic [NUM_CH-1:0]     over_range,
    output logic                  timeout_err,
    output logic                  frame_tick,
    output logic [16*NUM_CH-1:0]  frame_data
);
    localparam int unsigned ACC_W  = 12 + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;
    localparam int unsigned FRM_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned WAIT_W = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  BURST_LEN = CNT_W'(2 ** AVG_LOG2);
    localparam logic [2:0]        PTR_LAST  = 3'(NUM_CH - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(FRAME_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DRDY_TIMEOUT - 1);

    typedef enum logic [1:0] {StSelect, StWaitEoc, StWaitDrdy, StEmit} state_e;

    state_e              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d, ptr_inc;
    logic [6:0]          daddr_q, daddr_d, ch_addr;
    logic                ch_hit;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                burst_ovr_q, burst_ovr_d, sample_ovr;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                den_q, den_d;
    logic [15:0]         sample_data_q, sample_data_d;
    logic [2:0]          sample_ch_q, sample_ch_d;
    logic                sample_valid_q, sample_valid_d;
    logic [NUM_CH-1:0]   over_range_q, over_range_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         shadow_q [NUM_CH];
    logic [15:0]         shadow_d [NUM_CH];
    logic [FRM_W-1:0]    frm_q, frm_d;
    logic                frame_tick_q, frame_tick_d;
    logic [16*NUM_CH-1:0] frame_data_q, frame_data_d;

    always_comb begin
        ch_hit  = 1'b0;
        ch_addr = 7'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ptr_q == 3'(i)) begin
                ch_hit  = ch_en[i];
                ch_addr = ADDR_LIST[7*i +: 7];
            end
        end
    end

    assign ptr_inc    = (ptr_q == PTR_LAST) ? 3'd0 : ptr_q + 3'd1;
    assign acc_sum    = acc_q + ACC_W'(do_in[15:4]);
    assign sample_ovr = (do_in > OVR_THRESH);

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        daddr_d        = daddr_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        burst_ovr_d    = burst_ovr_q;
        wait_d         = wait_q;
        den_d          = 1'b0;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        over_range_d   = over_range_q;
        timeout_d      = timeout_q;
        shadow_d       = shadow_q;
        case (state_q)
            StSelect: begin
                if (ch_hit) begin
                    daddr_d     = ch_addr;
                    acc_d       = '0;
                    cnt_d       = '0;
                    burst_ovr_d = 1'b0;
                    state_d     = StWaitEoc;
                end else begin
                    ptr_d = ptr_inc;
                end
            end
            StWaitEoc: begin
                if (eoc_in) begin
                    den_d   = 1'b1;
                    wait_d  = '0;
                    state_d = StWaitDrdy;
                end
            end
            StWaitDrdy: begin
                if (drdy_in) begin
                    acc_d       = acc_sum;
                    cnt_d       = cnt_q + CNT_W'(1);
                    burst_ovr_d = burst_ovr_q | sample_ovr;
                    // Outputs are registered here so they appear during the StEmit cycle.
                    if (cnt_q + CNT_W'(1) == BURST_LEN) begin
                        sample_data_d  = {acc_sum[ACC_W-1 -: 12], 4'b0000};
                        sample_ch_d    = ptr_q;
                        sample_valid_d = 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (ptr_q == 3'(i)) begin
                                shadow_d[i]     = {acc_sum[ACC_W-1 -: 12], 4'b0000};
                                over_range_d[i] = burst_ovr_q | sample_ovr;
                            end
                        end
                        state_d = StEmit;
                    end else begin
                        state_d = StWaitEoc;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    ptr_d     = ptr_inc;
                    state_d   = StSelect;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StEmit: begin
                ptr_d   = ptr_inc;
                state_d = StSelect;
            end
            default: state_d = StSelect;
        endcase
    end

    // Snapshot reads the next-state shadow so an emit on the terminal cycle is included.
    always_comb begin
        frm_d        = (frm_q == FRM_LAST) ? '0 : frm_q + FRM_W'(1);
        frame_tick_d = (frm_q == FRM_LAST);
        frame_data_d = frame_data_q;
        if (frm_q == FRM_LAST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                frame_data_d[16*i +: 16] = shadow_d[i];
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q        <= StSelect;
            ptr_q          <= '0;
            daddr_q        <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            burst_ovr_q    <= 1'b0;
            wait_q         <= '0;
            den_q          <= 1'b0;
            sample_data_q  <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            over_range_q   <= '0;
            timeout_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
            frm_q          <= '0;
            frame_tick_q   <= 1'b0;
            frame_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            daddr_q        <= daddr_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            burst_ovr_q    <= burst_ovr_d;
            wait_q         <= wait_d;
            den_q          <= den_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            over_range_q   <= over_range_d;
            timeout_q      <= timeout_d;
            shadow_q       <= shadow_d;
            frm_q          <= frm_d;
            frame_tick_q   <= frame_tick_d;
            frame_data_q   <= frame_data_d;
        end
    end

    assign den_out      = den_q;
    assign daddr_out    = daddr_q;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign over_range   = over_range_q;
    assign timeout_err  = timeout_q;
    assign frame_tick   = frame_tick_q;
    assign frame_data   = frame_data_q;

endmodule

// File: tb/tb_xadc_scan_avg.sv
// Bench for xadc_scan_avg: reactive XADC/DRP model driven from a read-data pattern,
// expected burst averages queued as stimulus is set up and popped on each sample_valid.
`timescale 1ns/1ps
module tb_xadc_scan_avg;
    localparam int          FRAME  = 100;
    localparam logic [15:0] THRESH = 16'hFFD0;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
        logic        ovr;
    } exp_t;

    logic        CLK100MHZ  = 1'b0;
    logic        CPU_RESETN = 1'b1;
    logic [3:0]  ch_en      = 4'b0000;
    logic        eoc_in     = 1'b0;
    logic        drdy_in    = 1'b0;
    logic [15:0] do_in      = 16'h0000;
    logic        den_out;
    logic [6:0]  daddr_out;
    logic [15:0] sample_data;
    logic [2:0]  sample_ch;
    logic        sample_valid;
    logic [3:0]  over_range;
    logic        timeout_err;
    logic        frame_tick;
    logic [63:0] frame_data;

    xadc_scan_avg #(
        .NUM_CH      (4),
        .ADDR_LIST   ({7'h1F, 7'h1E, 7'h17, 7'h16}),
        .AVG_LOG2    (2),
        .FRAME_CYCLES(FRAME),
        .OVR_THRESH  (THRESH),
        .DRDY_TIMEOUT(255)
    ) dut (
        .CLK100MHZ   (CLK100MHZ),
        .CPU_RESETN  (CPU_RESETN),
        .ch_en       (ch_en),
        .eoc_in      (eoc_in),
        .drdy_in     (drdy_in),
        .do_in       (do_in),
        .den_out     (den_out),
        .daddr_out   (daddr_out),
        .sample_data (sample_data),
        .sample_ch   (sample_ch),
        .sample_valid(sample_valid),
        .over_range  (over_range),
        .timeout_err (timeout_err),
        .frame_tick  (frame_tick),
        .frame_data  (frame_data)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    logic [6:0]  addr_tab [4] = '{7'h16, 7'h17, 7'h1E, 7'h1F};
    logic [15:0] pattern [16];
    exp_t        exp_q [$];
    logic [15:0] exp_frame [4];
    logic [3:0]  exp_ovr;
    int          n_chk = 0, n_pass = 0, n_fail = 0;
    int          cyc = 0, den_cnt = 0, coinc_cnt = 0;
    int          rd_idx = 0, pend = 0, delay = 0, eoc_cnt = 0;
    logic        eoc_on = 1'b0, suppress_ch0 = 1'b0, frame_align = 1'b0;
    logic [6:0]  last_den_addr = 7'h00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_enabled(input logic [6:0] a);
        for (int i = 0; i < 4; i++) if (ch_en[i] && a == addr_tab[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_burst(input int ch, input int base);
        exp_t e;
        logic [13:0] sum = '0;
        logic ovr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sum = sum + 14'(pattern[(base + k) % 16][15:4]);
            ovr = ovr | (pattern[(base + k) % 16] > THRESH);
        end
        e.ch   = 3'(ch);
        e.data = {sum[13:2], 4'h0};
        e.ovr  = ovr;
        exp_q.push_back(e);
    endtask

    always @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) cyc <= 0;
        else             cyc <= cyc + 1;
    end

    // Scoreboard/monitor first, then the XADC model drives the next inputs.
    always @(negedge CLK100MHZ) begin
        exp_t e;
        if (!CPU_RESETN) begin
            rd_idx = 0; pend = 0; delay = 0; eoc_cnt = 0;
            drdy_in = 1'b0; eoc_in = 1'b0; exp_ovr = 4'b0000;
            for (int i = 0; i < 4; i++) exp_frame[i] = 16'h0000;
        end else begin
            if (sample_valid) begin
                check("sample_expected", {63'b0, sample_valid}, {63'b0, (exp_q.size() != 0)});
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    exp_frame[e.ch] = e.data;
                    exp_ovr[e.ch]   = e.ovr;
                    check("sample_ch", sample_ch, e.ch);
                    check("sample_data", sample_data, e.data);
                    check("burst_daddr", last_den_addr, addr_tab[e.ch[1:0]]);
                    check("over_range", over_range, exp_ovr);
                    if (exp_q.size() == 0) eoc_on = 1'b0;
                end
            end
            if (frame_tick) begin
                check("frame_period", cyc % FRAME, 0);
                check("frame_data", frame_data,
                      {exp_frame[3], exp_frame[2], exp_frame[1], exp_frame[0]});
                if (sample_valid) coinc_cnt++;
            end
            if (den_out) begin
                den_cnt++;
                last_den_addr = daddr_out;
                check("den_addr_enabled", addr_enabled(daddr_out), 1);
                if (!(suppress_ch0 && daddr_out == 7'h16)) begin
                    pend  = 1;
                    delay = 3;
                end
            end
            drdy_in = 1'b0;
            if (pend != 0 && delay > 0) begin
                delay--;
            end else if (pend != 0 &&
                         (!frame_align || (rd_idx % 4) != 3 || (cyc % FRAME) == FRAME - 1)) begin
                drdy_in = 1'b1;
                do_in   = pattern[rd_idx % 16];
                rd_idx++;
                pend    = 0;
            end
            eoc_cnt++;
            eoc_in = eoc_on && (eoc_cnt % 8 == 0);
        end
    end

    task automatic do_reset();
        CPU_RESETN = 1'b0;
        eoc_on     = 1'b0;
        ch_en      = 4'b0000;
        exp_q.delete();
        repeat (3) @(posedge CLK100MHZ);
        #1 CPU_RESETN = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge CLK100MHZ);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_den(input int budget, input string tag);
        int n = 0;
        @(posedge CLK100MHZ); #2;
        while (den_out !== 1'b1 && n < budget) begin
            @(posedge CLK100MHZ); #2;
            n++;
        end
        check(tag, den_out, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pattern[i] = 16'h8000;
        #1 CPU_RESETN = 1'b0;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        check("reset_outputs", {den_out, daddr_out, sample_data, sample_ch, sample_valid,
                                over_range, timeout_err, frame_tick}, 0);
        check("reset_frame_data", frame_data, 0);

        // All channels, constant mid-scale reads.
        do_reset();
        for (int k = 0; k < 8; k++) push_burst(k % 4, 4 * k);
        ch_en = 4'b1111; eoc_on = 1'b1;
        wait_drain(2000, "p1_drain");

        // Sparse enable, ramped burst -> truncated average.
        do_reset();
        for (int i = 0; i < 16; i++) pattern[i] = 16'h1000 * 16'((i % 4) + 1);
        push_burst(0, 0); push_burst(2, 4); push_burst(0, 8); push_burst(2, 12);
        ch_en = 4'b0101; eoc_on = 1'b1;
        wait_drain(2000, "p2_drain");

        // No channel enabled: no DRP traffic, then channel 3 only.
        do_reset();
        for (int i = 0; i < 16; i++) pattern[i] = 16'h8000;
        den_cnt = 0; eoc_on = 1'b1;
        repeat (1000) @(posedge CLK100MHZ);
        check("idle_no_den", den_cnt, 0);
        push_burst(3, 0);
        ch_en = 4'b1000;
        wait_den(100, "p3_den");
        check("p3_first_addr", daddr_out, 7'h1F);
        wait_drain(500, "p3_drain");

        // Over-range sample in one ch1 burst, clean ch1 burst afterwards.
        do_reset();
        pattern[1] = 16'hFFE0;
        push_burst(1, 0); push_burst(1, 4);
        ch_en = 4'b0010; eoc_on = 1'b1;
        wait_drain(1000, "p4_drain");
        check("p4_ovr_cleared", over_range, 0);

        // Channel 0 never answers: timeout, skip to channel 1.
        do_reset();
        for (int i = 0; i < 16; i++) pattern[i] = 16'h8000;
        suppress_ch0 = 1'b1;
        push_burst(1, 0); push_burst(1, 4);
        ch_en = 4'b0011; eoc_on = 1'b1;
        wait_den(100, "p5_den");
        check("p5_den_addr", daddr_out, 7'h16);
        repeat (200) @(posedge CLK100MHZ);
        check("p5_no_early_timeout", timeout_err, 0);
        wait_drain(3000, "p5_drain");
        check("p5_timeout_err", timeout_err, 1);

        // Asynchronous reset while den_out is high.
        eoc_on = 1'b1;
        wait_den(100, "p5_mid_den");
        #1 CPU_RESETN = 1'b0;
        #1;
        check("async_reset_outputs", {den_out, daddr_out, sample_data, sample_ch, sample_valid,
                                      over_range, timeout_err, frame_tick}, 0);
        check("async_reset_frame", frame_data, 0);
        suppress_ch0 = 1'b0;

        // Emits aligned to the frame terminal count.
        do_reset();
        for (int i = 0; i < 16; i++) pattern[i] = 16'h1230 + 16'h0450 * 16'(i);
        frame_align = 1'b1; coinc_cnt = 0;
        push_burst(0, 0); push_burst(0, 4); push_burst(0, 8); push_burst(0, 12);
        ch_en = 4'b0001; eoc_on = 1'b1;
        wait_drain(1000, "p6_drain");
        check("p6_coincident_emits", coinc_cnt, 4);
        repeat (120) @(posedge CLK100MHZ);
        frame_align = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
